// File: rtl/kpn_adder_node.sv
// KPN adder node: blocking read of one token from channel A, then one from channel B,
// then a blocking write of their sum to the output FIFO. Strict A-then-B order keeps the network deterministic.
module kpn_adder_node #(
    parameter int BITS_NUMBER = 16,
    parameter bit SATURATE    = 1'b0,
    parameter int COUNT_BITS  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   empty_a,
    output logic                   rd_a,
    input  logic [BITS_NUMBER-1:0] data_a,
    input  logic                   empty_b,
    output logic                   rd_b,
    input  logic [BITS_NUMBER-1:0] data_b,
    input  logic                   full_out,
    output logic                   wr_out,
    output logic [BITS_NUMBER-1:0] data_out,
    output logic                   busy,
    output logic                   overflow,
    output logic [COUNT_BITS-1:0]  token_count,
    output logic [2:0]             state_dbg
);

    // FIFO handshake: rd_a/rd_b/wr_out are one-cycle Moore pulses, issued only after the matching
    // empty/full flag was seen low in a WAIT state; read data is taken the cycle after the rd pulse,
    // and data_out is stable for the whole wr_out cycle. At most one strobe is high in any cycle.
    typedef enum logic [2:0] {
        S_WAIT_A   = 3'd0,
        S_RD_A     = 3'd1,
        S_CAP_A    = 3'd2,
        S_WAIT_B   = 3'd3,
        S_RD_B     = 3'd4,
        S_CAP_B    = 3'd5,
        S_WAIT_OUT = 3'd6,
        S_WR       = 3'd7
    } state_t;

    state_t state;
    state_t state_next;

    logic [BITS_NUMBER-1:0] reg_a;
    logic [BITS_NUMBER:0]   sum_wide;
    logic                   carry;
    logic [BITS_NUMBER-1:0] sum_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_WAIT_A:   if (!empty_a) state_next = S_RD_A;
            S_RD_A:     state_next = S_CAP_A;
            S_CAP_A:    state_next = S_WAIT_B;
            S_WAIT_B:   if (!empty_b) state_next = S_RD_B;
            S_RD_B:     state_next = S_CAP_B;
            S_CAP_B:    state_next = S_WAIT_OUT;
            S_WAIT_OUT: if (!full_out) state_next = S_WR;
            S_WR:       state_next = S_WAIT_A;
            default:    state_next = S_WAIT_A;
        endcase
    end

    always_comb begin
        rd_a   = (state == S_RD_A);
        rd_b   = (state == S_RD_B);
        wr_out = (state == S_WR);
        busy   = (state != S_WAIT_A);
    end

    assign state_dbg = state;

    // One extra bit catches the carry; saturation clamps to all-ones only when it fires.
    always_comb begin
        sum_wide   = {1'b0, reg_a} + {1'b0, data_b};
        carry      = sum_wide[BITS_NUMBER];
        sum_result = sum_wide[BITS_NUMBER-1:0];
        if (SATURATE && carry) begin
            sum_result = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_a       <= '0;
            data_out    <= '0;
            overflow    <= 1'b0;
            token_count <= '0;
        end else begin
            if (state == S_CAP_A) begin
                reg_a <= data_a;
            end
            if (state == S_CAP_B) begin
                data_out <= sum_result;
                overflow <= overflow | carry;
            end
            if (state == S_WR) begin
                token_count <= token_count + COUNT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_kpn_adder_node.sv
// Bench for kpn_adder_node: FIFO models around a wrapping and a saturating instance sharing inputs,
// with expected sums produced by plain integer arithmetic.
module tb_kpn_adder_node;
    localparam int W   = 16;
    localparam int CW  = 16;
    localparam int SCW = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic empty_a = 1'b1;
    logic empty_b = 1'b1;
    logic full_out = 1'b0;
    logic [W-1:0] data_a = '0;
    logic [W-1:0] data_b = '0;

    logic rd_a, rd_b, wr_out, busy, overflow;
    logic [W-1:0] data_out;
    logic [CW-1:0] token_count;
    logic [2:0] state_dbg;
    logic s_rd_a, s_rd_b, s_wr_out, s_busy, s_overflow;
    logic [W-1:0] s_data_out;
    logic [SCW-1:0] s_token_count;
    logic [2:0] s_state_dbg;

    int total = 0;
    int bad = 0;
    int clash = 0;
    int cyc = 0;
    int model_count = 0;
    logic model_ovf = 1'b0;
    logic [W-1:0] a_q[$], b_q[$], exp_q[$], exp_sat_q[$], got_q[$], got_sat_q[$];
    int rd_a_cyc[$], rd_b_cyc[$], wr_cyc[$];
    logic [W-1:0] g, gs, e, es;

    kpn_adder_node #(.BITS_NUMBER(W), .SATURATE(1'b0), .COUNT_BITS(CW)) dut (
        .clk(clk), .reset(reset),
        .empty_a(empty_a), .rd_a(rd_a), .data_a(data_a),
        .empty_b(empty_b), .rd_b(rd_b), .data_b(data_b),
        .full_out(full_out), .wr_out(wr_out), .data_out(data_out),
        .busy(busy), .overflow(overflow), .token_count(token_count), .state_dbg(state_dbg)
    );

    kpn_adder_node #(.BITS_NUMBER(W), .SATURATE(1'b1), .COUNT_BITS(SCW)) dut_sat (
        .clk(clk), .reset(reset),
        .empty_a(empty_a), .rd_a(s_rd_a), .data_a(data_a),
        .empty_b(empty_b), .rd_b(s_rd_b), .data_b(data_b),
        .full_out(full_out), .wr_out(s_wr_out), .data_out(s_data_out),
        .busy(s_busy), .overflow(s_overflow), .token_count(s_token_count), .state_dbg(s_state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO models and output scoreboard capture, all on the negative edge.
    always @(negedge clk) begin
        if (rd_a) begin
            rd_a_cyc.push_back(cyc);
            if (a_q.size() > 0) data_a <= a_q.pop_front();
        end
        if (rd_b) begin
            rd_b_cyc.push_back(cyc);
            if (b_q.size() > 0) data_b <= b_q.pop_front();
        end
        if (wr_out) begin
            wr_cyc.push_back(cyc);
            got_q.push_back(data_out);
        end
        if (s_wr_out) got_sat_q.push_back(s_data_out);
        if ((int'(rd_a) + int'(rd_b) + int'(wr_out)) > 1 ||
            {rd_a, rd_b, wr_out, busy, state_dbg} !== {s_rd_a, s_rd_b, s_wr_out, s_busy, s_state_dbg})
            clash <= clash + 1;
        empty_a <= (a_q.size() == 0);
        empty_b <= (b_q.size() == 0);
    end

    function automatic logic [W-1:0] ref_wrap(input int a, input int b);
        return W'((a + b) % (1 << W));
    endfunction

    function automatic logic [W-1:0] ref_sat(input int a, input int b);
        if (a + b > (1 << W) - 1) return {W{1'b1}};
        return W'(a + b);
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
        rd_a_cyc.delete();
        rd_b_cyc.delete();
        wr_cyc.delete();
    endtask

    task automatic push_a(input int a);
        a_q.push_back(W'(a));
    endtask

    task automatic push_b(input int b);
        b_q.push_back(W'(b));
    endtask

    task automatic expect_sum(input int a, input int b);
        exp_q.push_back(ref_wrap(a, b));
        exp_sat_q.push_back(ref_sat(a, b));
        model_count++;
        if (a + b >= (1 << W)) model_ovf = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({rd_a, rd_b, wr_out, busy, overflow} !== 5'b0 || data_out !== '0 || token_count !== '0) begin
            bad++;
            $display("FAIL reset_outputs got strobes/busy/ovf=%b data=%h count=%0d required all zero",
                     {rd_a, rd_b, wr_out, busy, overflow}, data_out, token_count);
        end
        total++;
        if ({s_rd_a, s_rd_b, s_wr_out, s_busy, s_overflow} !== 5'b0 || s_data_out !== '0 || s_token_count !== '0) begin
            bad++;
            $display("FAIL reset_outputs_sat got strobes/busy/ovf=%b data=%h count=%0d required all zero",
                     {s_rd_a, s_rd_b, s_wr_out, s_busy, s_overflow}, s_data_out, s_token_count);
        end
        reset = 1'b0;
        model_count = 0;
        model_ovf = 1'b0;
    endtask

    task automatic test_basic();
        int t0;
        sync();
        t0 = cyc;
        push_a(3);
        push_b(4);
        expect_sum(3, 4);
        for (int i = 0; i < 30 && got_q.size() < 1; i++) @(negedge clk);
        @(negedge clk);
        total++;
        if (rd_a_cyc.size() != 1 || rd_a_cyc[0] != t0 + 1) begin
            bad++;
            $display("FAIL basic_rd_a_cycle got count=%0d first=%0d required one at 1",
                     rd_a_cyc.size(), rd_a_cyc.size() > 0 ? rd_a_cyc[0] - t0 : -1);
        end
        total++;
        if (rd_b_cyc.size() != 1 || rd_b_cyc[0] != t0 + 4) begin
            bad++;
            $display("FAIL basic_rd_b_cycle got count=%0d first=%0d required one at 4",
                     rd_b_cyc.size(), rd_b_cyc.size() > 0 ? rd_b_cyc[0] - t0 : -1);
        end
        total++;
        if (wr_cyc.size() != 1 || wr_cyc[0] != t0 + 7) begin
            bad++;
            $display("FAIL basic_wr_cycle got count=%0d first=%0d required one at 7",
                     wr_cyc.size(), wr_cyc.size() > 0 ? wr_cyc[0] - t0 : -1);
        end
        total++;
        if (got_q.size() == 0 || got_sat_q.size() == 0 || exp_q.size() == 0) begin
            bad++;
            $display("FAIL basic_sum got no output token required 1");
        end else begin
            g = got_q.pop_front(); gs = got_sat_q.pop_front();
            e = exp_q.pop_front(); es = exp_sat_q.pop_front();
            if ({g, gs} !== {e, es}) begin
                bad++;
                $display("FAIL basic_sum got=%h/%h required=%h/%h", g, gs, e, es);
            end
        end
        total++;
        if (token_count !== CW'(model_count)) begin
            bad++;
            $display("FAIL basic_count got=%0d required=%0d", token_count, model_count);
        end
    endtask

    task automatic test_overflow();
        sync();
        push_a(16'hFFFF);
        push_b(2);
        expect_sum(16'hFFFF, 2);
        push_a(1);
        push_b(1);
        expect_sum(1, 1);
        for (int i = 0; i < 40 && got_q.size() < 2; i++) @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (got_q.size() == 0 || got_sat_q.size() == 0 || exp_q.size() == 0) begin
                bad++;
                $display("FAIL overflow_sum missing token %0d", i);
            end else begin
                g = got_q.pop_front(); gs = got_sat_q.pop_front();
                e = exp_q.pop_front(); es = exp_sat_q.pop_front();
                if ({g, gs} !== {e, es}) begin
                    bad++;
                    $display("FAIL overflow_sum token %0d got=%h/%h required=%h/%h", i, g, gs, e, es);
                end
            end
        end
        total++;
        if ({overflow, s_overflow} !== {model_ovf, model_ovf}) begin
            bad++;
            $display("FAIL overflow_sticky got=%b/%b required=%b", overflow, s_overflow, model_ovf);
        end
    endtask

    task automatic test_full();
        int t0;
        full_out = 1'b1;
        sync();
        t0 = cyc;
        push_a(10);
        push_b(20);
        expect_sum(10, 20);
        while (cyc < t0 + 10) @(negedge clk);
        total++;
        if (wr_cyc.size() != 0 || exp_q.size() == 0 || data_out !== exp_q[0] || s_data_out !== exp_sat_q[0] || busy !== 1'b1) begin
            bad++;
            $display("FAIL full_hold got writes=%0d data=%h/%h busy=%b required no write, data held, busy",
                     wr_cyc.size(), data_out, s_data_out, busy);
        end
        full_out = 1'b0;
        for (int i = 0; i < 20 && got_q.size() < 1; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        total++;
        if (wr_cyc.size() != 1 || wr_cyc[0] != t0 + 11) begin
            bad++;
            $display("FAIL full_release got writes=%0d first=%0d required one at 11",
                     wr_cyc.size(), wr_cyc.size() > 0 ? wr_cyc[0] - t0 : -1);
        end
        total++;
        if (got_q.size() == 0 || got_sat_q.size() == 0 || exp_q.size() == 0) begin
            bad++;
            $display("FAIL full_sum got no output token required 1");
        end else begin
            g = got_q.pop_front(); gs = got_sat_q.pop_front();
            e = exp_q.pop_front(); es = exp_sat_q.pop_front();
            if ({g, gs} !== {e, es}) begin
                bad++;
                $display("FAIL full_sum got=%h/%h required=%h/%h", g, gs, e, es);
            end
        end
    endtask

    task automatic test_wait_b();
        sync();
        push_a(5);
        repeat (13) @(negedge clk);
        total++;
        if (rd_a_cyc.size() != 1 || rd_b_cyc.size() != 0 || busy !== 1'b1 || got_q.size() != 0) begin
            bad++;
            $display("FAIL wait_b_hold got rd_a=%0d rd_b=%0d busy=%b outs=%0d required 1 0 1 0",
                     rd_a_cyc.size(), rd_b_cyc.size(), busy, got_q.size());
        end
        push_b(6);
        expect_sum(5, 6);
        for (int i = 0; i < 30 && got_q.size() < 1; i++) @(negedge clk);
        @(negedge clk);
        total++;
        if (got_q.size() == 0 || got_sat_q.size() == 0 || exp_q.size() == 0) begin
            bad++;
            $display("FAIL wait_b_sum got no output token required 1");
        end else begin
            g = got_q.pop_front(); gs = got_sat_q.pop_front();
            e = exp_q.pop_front(); es = exp_sat_q.pop_front();
            if ({g, gs} !== {e, es}) begin
                bad++;
                $display("FAIL wait_b_sum got=%h/%h required=%h/%h", g, gs, e, es);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        sync();
        t0 = cyc;
        push_a(7);
        push_b(8);
        while (cyc < t0 + 5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({rd_a, rd_b, wr_out, busy, overflow} !== 5'b0 || data_out !== '0 || token_count !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs got strobes/busy/ovf=%b data=%h count=%0d required all zero",
                     {rd_a, rd_b, wr_out, busy, overflow}, data_out, token_count);
        end
        reset = 1'b0;
        model_count = 0;
        model_ovf = 1'b0;
        repeat (12) @(negedge clk);
        total++;
        if (got_q.size() != 0 || got_sat_q.size() != 0) begin
            bad++;
            $display("FAIL reset_mid_no_write got outs=%0d required 0", got_q.size());
        end
        sync();
        push_a(1);
        push_b(1);
        expect_sum(1, 1);
        for (int i = 0; i < 30 && got_q.size() < 1; i++) @(negedge clk);
        @(negedge clk);
        total++;
        if (got_q.size() == 0 || got_sat_q.size() == 0 || exp_q.size() == 0) begin
            bad++;
            $display("FAIL reset_mid_sum got no output token required 1");
        end else begin
            g = got_q.pop_front(); gs = got_sat_q.pop_front();
            e = exp_q.pop_front(); es = exp_sat_q.pop_front();
            if ({g, gs} !== {e, es}) begin
                bad++;
                $display("FAIL reset_mid_sum got=%h/%h required=%h/%h", g, gs, e, es);
            end
        end
        total++;
        if (token_count !== CW'(model_count)) begin
            bad++;
            $display("FAIL reset_mid_count got=%0d required=%0d", token_count, model_count);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        sync();
        t0 = cyc;
        for (int k = 1; k <= 3; k++) begin
            push_a(k);
            push_b(k);
            expect_sum(k, k);
        end
        for (int i = 0; i < 60 && got_q.size() < 3; i++) @(negedge clk);
        @(negedge clk);
        total++;
        if (wr_cyc.size() != 3 || wr_cyc[0] != t0 + 7 || wr_cyc[1] - wr_cyc[0] != 8 || wr_cyc[2] - wr_cyc[1] != 8) begin
            bad++;
            $display("FAIL b2b_spacing got writes=%0d first=%0d required 3 writes at 7 spaced 8",
                     wr_cyc.size(), wr_cyc.size() > 0 ? wr_cyc[0] - t0 : -1);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got_q.size() == 0 || got_sat_q.size() == 0 || exp_q.size() == 0) begin
                bad++;
                $display("FAIL b2b_sum missing token %0d", i);
            end else begin
                g = got_q.pop_front(); gs = got_sat_q.pop_front();
                e = exp_q.pop_front(); es = exp_sat_q.pop_front();
                if ({g, gs} !== {e, es}) begin
                    bad++;
                    $display("FAIL b2b_sum token %0d got=%h/%h required=%h/%h", i, g, gs, e, es);
                end
            end
        end
        total++;
        if (token_count !== CW'(model_count)) begin
            bad++;
            $display("FAIL b2b_count got=%0d required=%0d", token_count, model_count);
        end
    endtask

    task automatic test_random();
        int a;
        int b;
        int n;
        n = 24;
        sync();
        for (int k = 0; k < n; k++) begin
            a = int'($urandom_range(0, 65535));
            b = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) a = 65535 - int'($urandom_range(0, 3));
            push_a(a);
            full_out = ($urandom_range(0, 2) == 0);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            push_b(b);
            expect_sum(a, b);
            repeat ($urandom_range(1, 6)) begin
                @(posedge clk);
                #1;
            end
        end
        full_out = 1'b0;
        for (int i = 0; i < n * 10 + 50 && got_q.size() < n; i++) @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            total++;
            if (got_q.size() == 0 || got_sat_q.size() == 0 || exp_q.size() == 0) begin
                bad++;
                $display("FAIL random_sum missing token %0d", i);
            end else begin
                g = got_q.pop_front(); gs = got_sat_q.pop_front();
                e = exp_q.pop_front(); es = exp_sat_q.pop_front();
                if ({g, gs} !== {e, es}) begin
                    bad++;
                    $display("FAIL random_sum token %0d got=%h/%h required=%h/%h", i, g, gs, e, es);
                end
            end
        end
        total++;
        if (token_count !== CW'(model_count) || s_token_count !== model_count[SCW-1:0]) begin
            bad++;
            $display("FAIL random_count got=%0d/%0d required=%0d/%0d",
                     token_count, s_token_count, model_count, model_count[SCW-1:0]);
        end
        total++;
        if ({overflow, s_overflow} !== {model_ovf, model_ovf}) begin
            bad++;
            $display("FAIL random_overflow got=%b/%b required=%b", overflow, s_overflow, model_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full();
        test_wait_b();
        test_reset_mid();
        test_back_to_back();
        test_random();
        total++;
        if (clash != 0) begin
            bad++;
            $display("FAIL strobe_exclusive got clashes=%0d required 0", clash);
        end
        total++;
        if (got_q.size() != 0 || exp_q.size() != 0 || got_sat_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_tokens got outs=%0d expected_left=%0d required 0 0", got_q.size(), exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
